demux_1to2_buf: RTL and testbench

//  Buffered 1-to-2 demultiplexer for the nibble-processor datapath; inverse of the 2-to-1 operand mux.

---
 rtl/demux_pkg.sv | 24 ++
 rtl/demux_fifo.sv | 61 ++++++
 rtl/demux_1to2_buf.sv | 96 +++++++++
 tb/tb_demux_1to2_buf.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-2 demultiplexer.
package demux_pkg;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned DEMUX_WIDTH = 8;
  localparam int unsigned DEMUX_DEPTH = 2;

  localparam logic DEMUX_PORT1 = 1'b0;
  localparam logic DEMUX_PORT2 = 1'b1;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  // Classify a FIFO occupancy count against its capacity.
  function automatic occ_e occ_of(input int unsigned count, input int unsigned depth);
    if (count == 0)          return OCC_EMPTY;
    else if (count >= depth) return OCC_FULL;
    else                     return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO: registered storage, head word visible one cycle after push.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  occ_e             occ;
  logic             push_ok;
  logic             pop_ok;

  assign occ     = occ_of(32'(count_q), DEPTH);
  assign full_o  = (occ == OCC_FULL);
  assign empty_o = (occ == OCC_EMPTY);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; power-of-two depth makes pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (pop_ok)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    if (push_ok && !pop_ok)      count_d = OCC_W'(count_q + 1'b1);
    else if (pop_ok && !push_ok) count_d = OCC_W'(count_q - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/demux_1to2_buf.sv
// Buffered 1-to-2 demux: sel steers the input stream into one of two per-port FIFOs.
// Optional transfer counters cnt1/cnt2 exist only when DEMUX_COUNT_EN is defined.
module demux_1to2_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned DEPTH = DEMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
`endif
);

  logic ready_q;
  logic full1, full2;
  logic empty1, empty2;
  logic accept, push1, push2;

  // Holds in_ready low through reset and for the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Ready depends only on the selected FIFO's fullness, never on downstream ready.
  assign in_ready = ready_q && !((sel == DEMUX_PORT2) ? full2 : full1);
  assign accept   = in_valid && in_ready;
  assign push1    = accept && (sel == DEMUX_PORT1);
  assign push2    = accept && (sel == DEMUX_PORT2);

  assign out1_valid = !empty1;
  assign out2_valid = !empty2;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push1),
    .data_i (in_data),
    .pop_i  (out1_ready),
    .head_o (out1_data),
    .full_o (full1),
    .empty_o(empty1)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push2),
    .data_i (in_data),
    .pop_i  (out2_ready),
    .head_o (out2_data),
    .full_o (full2),
    .empty_o(empty2)
  );

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  // Per-port accept counters, wrapping at the counter width.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (push1) cnt1_d = CNT_W'(cnt1_q + 1'b1);
    if (push2) cnt2_d = CNT_W'(cnt2_q + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Self-checking bench for demux_1to2_buf: directed scenarios plus random traffic vs a queue model.
module tb_demux_1to2_buf;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] out2_data;
`ifdef DEMUX_COUNT_EN
  logic [15:0]      cnt1;
  logic [15:0]      cnt2;
`endif

  demux_1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data),
    .out2_valid(out2_valid),
    .out2_ready(out2_ready),
    .out2_data (out2_data)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt1      (cnt1),
    .cnt2      (cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per port, an input-ready flag and accept counters.
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];
  bit               m_rdy;
  logic [15:0]      m_cnt1;
  logic [15:0]      m_cnt2;
  int               n_cmp;
  int               n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_rdy  = 1'b0;
    m_cnt1 = '0;
    m_cnt2 = '0;
  endtask

  // One clock: drive at posedge+1, compare at negedge, update model after the edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic s,
                       input logic r1, input logic r2);
    logic exp_rdy, acc, p1, p2;
    in_valid   = v;
    in_data    = d;
    sel        = s;
    out1_ready = r1;
    out2_ready = r2;
    #4;
    exp_rdy = m_rdy && ((s ? q2.size() : q1.size()) < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
    chk("out2_valid", 32'(out2_valid), 32'(q2.size() > 0));
    if (q1.size() > 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
    if (q2.size() > 0) chk("out2_data", 32'(out2_data), 32'(q2[0]));
`ifdef DEMUX_COUNT_EN
    chk("cnt1", 32'(cnt1), 32'(m_cnt1));
    chk("cnt2", 32'(cnt2), 32'(m_cnt2));
`endif
    acc = v && exp_rdy;
    p1  = (q1.size() > 0) && r1;
    p2  = (q2.size() > 0) && r2;
    @(posedge clk);
    #1;
    if (p1) void'(q1.pop_front());
    if (p2) void'(q2.pop_front());
    if (acc) begin
      if (s) begin q2.push_back(d); m_cnt2 = m_cnt2 + 16'd1; end
      else   begin q1.push_back(d); m_cnt1 = m_cnt1 + 16'd1; end
    end
    m_rdy = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
    chk({tag, "_out1_valid"}, 32'(out1_valid), 32'(0));
    chk({tag, "_out2_valid"}, 32'(out2_valid), 32'(0));
    chk({tag, "_out1_data"}, 32'(out1_data), 32'(0));
    chk({tag, "_out2_data"}, 32'(out2_data), 32'(0));
`ifdef DEMUX_COUNT_EN
    chk({tag, "_cnt1"}, 32'(cnt1), 32'(0));
    chk({tag, "_cnt2"}, 32'(cnt2), 32'(0));
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; sel = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_state("rst_init");
    rst_n = 1'b1;
    // Release cycle: in_ready must still be low (model m_rdy=0).
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Steering: A5 to port 1, 3C to port 2, each visible one cycle after accept.
    cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
    chk("t2_out1_valid", 32'(out1_valid), 32'(1));
    chk("t2_out1_data", 32'(out1_data), 32'h0A5);
    cycle(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    chk("t2_out2_valid", 32'(out2_valid), 32'(1));
    chk("t2_out2_data", 32'(out2_data), 32'h03C);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Back-pressure on port 1; port 2 keeps flowing.
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t3_full_in_ready", 32'(in_ready), 32'(0));
    cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    chk("t3_out2_data", 32'(out2_data), 32'h077);
    chk("t3_out1_held", 32'(out1_data), 32'h001);

    // Drain port 1 in order, then sel=0 becomes ready again.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("t4_out1_second", 32'(out1_data), 32'h002);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("t4_out1_empty", 32'(out1_valid), 32'(0));
    chk("t4_in_ready", 32'(in_ready), 32'(1));

    // Simultaneous push/pop with one entry resident.
    cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
    chk("t5_head10", 32'(out1_data), 32'h010);
    cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b1);
    chk("t5_head11", 32'(out1_data), 32'h011);
    chk("t5_ready11", 32'(in_ready), 32'(1));
    cycle(1'b1, 8'h12, 1'b0, 1'b1, 1'b1);
    chk("t5_head12", 32'(out1_data), 32'h012);
    chk("t5_valid12", 32'(out1_valid), 32'(1));
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("t5_empty", 32'(out1_valid), 32'(0));

    // Random traffic with biased downstream readiness.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
    end

    // Fill both ports, then reset mid-traffic.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'(i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("rst_mid_no_valid1", 32'(out1_valid), 32'(0));
    chk("rst_mid_no_valid2", 32'(out2_valid), 32'(0));

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 70000 accepts on port 2 only.
    for (int i = 0; i < 70000; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'($urandom), 1'b1);
    chk("t6_cnt2", 32'(cnt2), 32'd4464);
    chk("t6_cnt1", 32'(cnt1), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
